// File: rtl/i2c_eeprom_ctrl_if.sv
// Requester-side command/response bundle of the 24C02 byte controller.
interface i2c_eeprom_ctrl_if;
    logic [1:0] start_sig;
    logic [7:0] addr_sig;
    logic [7:0] wrdata;
    logic [7:0] rddata;
    logic       done_sig;
    logic       ack_err;

    // Requester holds start_sig (01 write, 10 read) plus addr_sig/wrdata until done_sig pulses
    // for one cycle; rddata and ack_err are valid in that cycle. start_sig must drop the cycle after.
    modport master (output start_sig, addr_sig, wrdata, input rddata, done_sig, ack_err);
    modport slave  (input start_sig, addr_sig, wrdata, output rddata, done_sig, ack_err);
endinterface

// File: rtl/i2c_eeprom_ctrl.sv
// Byte-level I2C master for a 24C02: one random-byte write or read per command,
// four quarter phases per SCL bit, open-drain SDA, push-pull SCL.
module i2c_eeprom_ctrl #(
    parameter int unsigned QDIV     = 125,
    parameter logic [6:0]  DEV_ADDR = 7'b1010_000,
    parameter int unsigned TWR      = 250_000
) (
    input  logic              sysclk,
    input  logic              rst,
    i2c_eeprom_ctrl_if.slave  req,
    output logic              scl,
    inout  wire               sda,
    output logic [3:0]        dbg_state
);
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_DEVW   = 4'd2,
        ST_WADDR  = 4'd3,
        ST_WDATA  = 4'd4,
        ST_RSTART = 4'd5,
        ST_DEVR   = 4'd6,
        ST_RDATA  = 4'd7,
        ST_STOP   = 4'd8,
        ST_TWAIT  = 4'd9,
        ST_DONE   = 4'd10
    } state_t;

    localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int TW = (TWR > 1) ? $clog2(TWR) : 1;
    localparam logic [QW-1:0] QLAST  = QW'(QDIV - 1);
    localparam logic [TW-1:0] TWLAST = TW'(TWR - 1);

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      q_q, q_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            cmd_rd_q, cmd_rd_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdat_q, wdat_d;
    logic            err_q, err_d;
    logic            samp_q, samp_d;
    logic [TW-1:0]   twcnt_q, twcnt_d;
    logic [7:0]      rddata_q, rddata_d;
    logic            done_q, done_d;
    logic            ack_err_q, ack_err_d;
    logic            scl_q, scl_d;
    logic            sda_low_q, sda_low_d;
    logic            tick;
    logic            bit_end;
    logic            sda_in;

    assign sda_in      = sda;
    assign sda         = sda_low_q ? 1'b0 : 1'bz;
    assign scl         = scl_q;
    assign dbg_state   = state_q;
    assign req.rddata  = rddata_q;
    assign req.done_sig = done_q;
    assign req.ack_err = ack_err_q;

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        q_d       = q_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        cmd_rd_d  = cmd_rd_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        err_d     = err_q;
        samp_d    = samp_q;
        twcnt_d   = twcnt_q;
        rddata_d  = rddata_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        tick      = 1'b0;
        bit_end   = 1'b0;

        // Quarter-phase timebase only runs while the bus is owned.
        if (state_q inside {ST_START, ST_DEVW, ST_WADDR, ST_WDATA,
                            ST_RSTART, ST_DEVR, ST_RDATA, ST_STOP}) begin
            tick    = (qcnt_q == QLAST);
            bit_end = tick && (q_q == 2'd3);
            qcnt_d  = tick ? '0 : qcnt_q + 1'b1;
            if (tick) q_d = q_q + 2'd1;
            if (q_q == 2'd2 && qcnt_q == '0) samp_d = sda_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (req.start_sig == 2'b01 || req.start_sig == 2'b10) begin
                    state_d  = ST_START;
                    cmd_rd_d = req.start_sig[1];
                    addr_d   = req.addr_sig;
                    wdat_d   = req.wrdata;
                    err_d    = 1'b0;
                    qcnt_d   = '0;
                    q_d      = 2'd0;
                    bitcnt_d = 4'd0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d  = ST_DEVW;
                    shreg_d  = {DEV_ADDR, 1'b0};
                    bitcnt_d = 4'd0;
                end
            end
            ST_DEVW, ST_WADDR, ST_WDATA, ST_DEVR, ST_RDATA: begin
                if (bit_end) begin
                    if (bitcnt_q != 4'd8) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        shreg_d  = {shreg_q[6:0], samp_q};
                    end else begin
                        // Ninth bit: ACK slot (or the master's NACK slot in RDATA).
                        bitcnt_d = 4'd0;
                        if (state_q == ST_RDATA) begin
                            state_d = ST_STOP;
                        end else if (samp_q) begin
                            err_d   = 1'b1;
                            state_d = ST_STOP;
                        end else begin
                            case (state_q)
                                ST_DEVW: begin
                                    state_d = ST_WADDR;
                                    shreg_d = addr_q;
                                end
                                ST_WADDR: begin
                                    if (cmd_rd_q) begin
                                        state_d = ST_RSTART;
                                    end else begin
                                        state_d = ST_WDATA;
                                        shreg_d = wdat_q;
                                    end
                                end
                                ST_WDATA: state_d = ST_STOP;
                                default:  state_d = ST_RDATA;
                            endcase
                        end
                    end
                end
            end
            ST_RSTART: begin
                if (bit_end) begin
                    state_d  = ST_DEVR;
                    shreg_d  = {DEV_ADDR, 1'b1};
                    bitcnt_d = 4'd0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!cmd_rd_q && !err_q) begin
                        state_d = ST_TWAIT;
                        twcnt_d = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_TWAIT: begin
                if (twcnt_q == TWLAST) begin
                    state_d = ST_DONE;
                    twcnt_d = '0;
                end else begin
                    twcnt_d = twcnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Line levels are registered from the position the FSM is about to occupy.
        case (state_d)
            ST_START: begin
                scl_d     = 1'b1;
                sda_low_d = (q_d >= 2'd2);
            end
            ST_RSTART: begin
                scl_d     = (q_d != 2'd0);
                sda_low_d = (q_d >= 2'd2);
            end
            ST_STOP: begin
                scl_d     = (q_d != 2'd0);
                sda_low_d = (q_d != 2'd3);
            end
            ST_DEVW, ST_WADDR, ST_WDATA, ST_DEVR: begin
                scl_d     = (q_d != 2'd0);
                sda_low_d = (bitcnt_d != 4'd8) && !shreg_d[7];
            end
            ST_RDATA: begin
                scl_d     = (q_d != 2'd0);
                sda_low_d = 1'b0;
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase

        if (state_d == ST_DONE) begin
            done_d    = 1'b1;
            ack_err_d = err_q;
            if (cmd_rd_q && !err_q) rddata_d = shreg_q;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            qcnt_q    <= '0;
            q_q       <= 2'd0;
            bitcnt_q  <= 4'd0;
            shreg_q   <= 8'h00;
            cmd_rd_q  <= 1'b0;
            addr_q    <= 8'h00;
            wdat_q    <= 8'h00;
            err_q     <= 1'b0;
            samp_q    <= 1'b0;
            twcnt_q   <= '0;
            rddata_q  <= 8'h00;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            q_q       <= q_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            cmd_rd_q  <= cmd_rd_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            err_q     <= err_d;
            samp_q    <= samp_d;
            twcnt_q   <= twcnt_d;
            rddata_q  <= rddata_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
        end
    end
endmodule
